dest_data_demux: RTL and testbench
==================================

// Module: dest_data_demux
//
// PURPOSE
//  Egress demultiplexer for the per-destination request arbiter.
//  - The arbiter merges N_DESTS request streams into one.
//  - For every granted request it pushes a sequence entry {pid, len, dest} into a queue.
//  - This block pops those entries in order and steers the single incoming AXI4S data
//    stream to destination port 'dest' for exactly len+1 beats.
//  - It regenerates tlast per transfer and flags any mismatch between the sequence and the data.
//
// PARAMETERS
//  DATA_BITS  AXI_DATA_BITS  AXI4S data width; tkeep width = DATA_BITS/8
//  N_DESTS    1              number of destination ports; N_DESTS_BITS = clog2s(N_DESTS), minimum 1
//
// PORTS
//  aclk         in   1                  clock
//  aresetn      in   1                  synchronous, active-low reset
//  mux          metaIntf.s  mux_user_t  sequence entry: .dest, .len (beats-1), .pid
//  s_axis       AXI4S.s  DATA_BITS      single merged data input (tdata/tkeep/tlast/tvalid/tready)
//  m_axis       AXI4S.m  [N_DESTS]      per-destination data outputs
//  seq_err      out  1                  sticky: tlast/length mismatch or dest out of range
//  active_dest  out  N_DESTS_BITS       dest latched for the current transfer (debug)
//
// BEHAVIOUR
//  State machine: IDLE, XFER.
//  Registers: dest_r, cnt (BLEN_BITS wide, holds beats remaining minus 1), pid_r, seq_err.
//
//  Reset (aresetn=0 at posedge):
//  - state=IDLE; cnt, dest_r, pid_r, seq_err all 0.
//  - Every m_axis[i].tvalid=0, s_axis.tready=0, mux.ready=1.
//  - A reset mid-XFER abandons the remainder. Residual beats are not tracked.
//
//  IDLE:
//  - mux.ready=1 and s_axis.tready=0. No data moves.
//  - On mux.valid: dest_r<=mux.data.dest, cnt<=mux.data.len, pid_r<=mux.data.pid, state<=XFER.
//  - Latency: the first beat can pass in the cycle after the pop.
//
//  XFER, dest_r < N_DESTS:
//  - m_axis[dest_r].tvalid = s_axis.tvalid; s_axis.tready = m_axis[dest_r].tready.
//  - All other m_axis[i].tvalid=0.
//  - tdata/tkeep are broadcast combinationally to every port. Zero-cycle data path.
//  - m_axis[dest_r].tlast = (cnt==0). The input tlast is not forwarded.
//  - On beat handshake: if cnt!=0 then cnt<=cnt-1; else the transfer ends.
//
//  XFER, dest_r >= N_DESTS:
//  - s_axis.tready=1 and the beats are discarded.
//  - seq_err<=1 on the first beat. The beat count is still honoured.
//
//  Transfer end and back-to-back:
//  - mux.ready is also 1 in XFER during the last-beat handshake (cnt==0 && s_axis.tvalid && s_axis.tready).
//  - If mux.valid is high in that cycle: load the new entry and stay in XFER. No bubble.
//  - Otherwise: state<=IDLE.
//
//  Mismatch:
//  - On any beat handshake where s_axis.tlast != (cnt==0): seq_err<=1.
//  - The beat is still routed. seq_err is cleared only by reset.
//
//  Other rules:
//  - No beat is ever accepted without a popped sequence entry.
//  - s_axis.tvalid in IDLE is held off, never dropped.
//  - Backpressure from m_axis[dest_r] stalls s_axis only. Other ports are unaffected.
//  - AXI stability: tvalid/tdata/tkeep on a stalled output stay stable because they mirror the stalled input.
//  - cnt arithmetic is unsigned. mux.data.len is zero-extended to BLEN_BITS.
//  - active_dest = dest_r.
//
// TESTING
//  1. N_DESTS=4; push {dest=2,len=3}, then 4 beats with tlast on beat 4
//     -> only m_axis[2] sees 4 beats, tlast on the 4th, seq_err=0, state IDLE afterwards.
//  2. Back-to-back {dest=0,len=0},{dest=3,len=1}, data valid every cycle
//     -> beats on ports 0,3,3 in consecutive cycles, no idle cycle between entries.
//  3. {dest=1,len=7}; m_axis[1].tready toggles 1,0,0,1...
//     -> s_axis.tready mirrors it, tdata stable while stalled, exactly 8 beats delivered.
//  4. {dest=0,len=2}; input tlast asserted on beat 2
//     -> seq_err=1 from the next cycle; 3 beats delivered; output tlast on beat 3 only.
//  5. N_DESTS=3; {dest=3,len=1}
//     -> 2 beats drained with tready=1, no m_axis tvalid, seq_err=1.
//  6. Assert aresetn=0 mid-XFER at beat 2 of 5
//     -> next cycle: IDLE, all tvalid=0, s_axis.tready=0, seq_err=0, mux.ready=1.

Source files
------------

// File: rtl/dest_data_demux.sv
// dest_data_demux - steers one merged AXI4S stream to per-destination ports in sequence-queue order
module dest_data_demux #(
    parameter int DATA_BITS = 64,
    parameter int N_DESTS   = 1,
    parameter int BLEN_BITS = 8,
    parameter int LEN_BITS  = 8,
    parameter int PID_BITS  = 6,
    localparam int N_DESTS_BITS = (N_DESTS > 1) ? $clog2(N_DESTS) : 1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                mux_valid,
    output logic                                mux_ready,
    input  logic [N_DESTS_BITS-1:0]             mux_dest,
    input  logic [LEN_BITS-1:0]                 mux_len,
    input  logic [PID_BITS-1:0]                 mux_pid,
    input  logic [DATA_BITS-1:0]                s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]              s_axis_tkeep,
    input  logic                                s_axis_tlast,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [N_DESTS-1:0][DATA_BITS-1:0]   m_axis_tdata,
    output logic [N_DESTS-1:0][DATA_BITS/8-1:0] m_axis_tkeep,
    output logic [N_DESTS-1:0]                  m_axis_tlast,
    output logic [N_DESTS-1:0]                  m_axis_tvalid,
    input  logic [N_DESTS-1:0]                  m_axis_tready,
    output logic                                seq_err,
    output logic [N_DESTS_BITS-1:0]             active_dest,
    output logic [PID_BITS-1:0]                 active_pid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]              state;
    logic [N_DESTS_BITS-1:0] dest_r;
    logic [BLEN_BITS-1:0]    cnt;
    logic [PID_BITS-1:0]     pid_r;

    logic in_range;
    logic last;
    logic hs;
    logic load;

    assign in_range = (32'(dest_r) < N_DESTS);
    assign last     = (cnt == '0);
    assign hs       = (state == XFER) && s_axis_tvalid && s_axis_tready;
    // A new entry may be popped while idle or in the very cycle the last beat completes.
    assign mux_ready = (state == IDLE) || (hs && last);
    assign load      = mux_valid && mux_ready;

    assign m_axis_tdata = {N_DESTS{s_axis_tdata}};
    assign m_axis_tkeep = {N_DESTS{s_axis_tkeep}};
    assign active_dest  = dest_r;
    assign active_pid   = pid_r;

    always_comb begin
        m_axis_tvalid = '0;
        m_axis_tlast  = '0;
        s_axis_tready = 1'b0;
        if (state == XFER) begin
            // Out-of-range destinations are drained so the stream does not lock up.
            if (!in_range) begin
                s_axis_tready = 1'b1;
            end
            for (int i = 0; i < N_DESTS; i++) begin
                if (in_range && 32'(dest_r) == i) begin
                    m_axis_tvalid[i] = s_axis_tvalid;
                    m_axis_tlast[i]  = last;
                    s_axis_tready    = m_axis_tready[i];
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            dest_r  <= '0;
            cnt     <= '0;
            pid_r   <= '0;
            seq_err <= 1'b0;
        end else begin
            if (load) begin
                dest_r <= mux_dest;
                cnt    <= BLEN_BITS'(mux_len);
                pid_r  <= mux_pid;
                state  <= XFER;
            end else if (hs && last) begin
                state <= IDLE;
            end
            if (hs) begin
                if (!last) begin
                    cnt <= cnt - 1'b1;
                end
                if (!in_range || (s_axis_tlast != last)) begin
                    seq_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dest_data_demux.sv
// tb/tb_dest_data_demux.sv - directed self-checking bench for dest_data_demux
module tb_dest_data_demux;

    logic        clk;
    logic        aresetn;
    logic        mux_valid;
    logic        mux_valid_b;
    logic [1:0]  mux_dest;
    logic [7:0]  mux_len;
    logic [5:0]  mux_pid;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tvalid_b;

    logic             mux_ready;
    logic             s_tready;
    logic [3:0][31:0] m_tdata;
    logic [3:0][3:0]  m_tkeep;
    logic [3:0]       m_tlast;
    logic [3:0]       m_tvalid;
    logic [3:0]       m_tready;
    logic             seq_err;
    logic [1:0]       active_dest;
    logic [5:0]       active_pid;

    logic             mux_ready_b;
    logic             s_tready_b;
    logic [2:0][31:0] m_tdata_b;
    logic [2:0][3:0]  m_tkeep_b;
    logic [2:0]       m_tlast_b;
    logic [2:0]       m_tvalid_b;
    logic [2:0]       m_tready_b;
    logic             seq_err_b;
    logic [1:0]       active_dest_b;
    logic [5:0]       active_pid_b;

    int total;
    int bad;

    dest_data_demux #(.DATA_BITS(32), .N_DESTS(4), .BLEN_BITS(8), .LEN_BITS(8), .PID_BITS(6)) dut (
        .aclk(clk), .aresetn(aresetn),
        .mux_valid(mux_valid), .mux_ready(mux_ready),
        .mux_dest(mux_dest), .mux_len(mux_len), .mux_pid(mux_pid),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .seq_err(seq_err), .active_dest(active_dest), .active_pid(active_pid)
    );

    dest_data_demux #(.DATA_BITS(32), .N_DESTS(3), .BLEN_BITS(8), .LEN_BITS(8), .PID_BITS(6)) dut_b (
        .aclk(clk), .aresetn(aresetn),
        .mux_valid(mux_valid_b), .mux_ready(mux_ready_b),
        .mux_dest(mux_dest), .mux_len(mux_len), .mux_pid(mux_pid),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid_b), .s_axis_tready(s_tready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tkeep(m_tkeep_b), .m_axis_tlast(m_tlast_b),
        .m_axis_tvalid(m_tvalid_b), .m_axis_tready(m_tready_b),
        .seq_err(seq_err_b), .active_dest(active_dest_b), .active_pid(active_pid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus on the 4-port DUT, check its combinational outputs, then clock.
    task automatic cyc(input string tag, input logic mv, input logic [1:0] md, input logic [7:0] ml,
                       input logic sv, input logic sl, input logic [31:0] sd,
                       input logic [3:0] e_tv, input logic [3:0] e_tl, input logic e_tr, input logic e_mr);
        mux_valid = mv;
        mux_dest  = md;
        mux_len   = ml;
        s_tvalid  = sv;
        s_tlast   = sl;
        s_tdata   = sd;
        #1;
        chk({tag, ".tvalid"}, 64'(m_tvalid), 64'(e_tv));
        chk({tag, ".tlast"}, 64'(m_tlast), 64'(e_tl));
        chk({tag, ".s_tready"}, 64'(s_tready), 64'(e_tr));
        chk({tag, ".mux_ready"}, 64'(mux_ready), 64'(e_mr));
        if (sv) begin
            for (int i = 0; i < 4; i++) chk({tag, ".tdata"}, 64'(m_tdata[i]), 64'(sd));
        end
        step();
    endtask

    initial begin
        int beats;
        logic tr;
        total       = 0;
        bad         = 0;
        aresetn     = 1'b0;
        mux_valid   = 1'b0;
        mux_valid_b = 1'b0;
        mux_dest    = '0;
        mux_len     = '0;
        mux_pid     = 6'h15;
        s_tdata     = '0;
        s_tkeep     = 4'hA;
        s_tlast     = 1'b0;
        s_tvalid    = 1'b0;
        s_tvalid_b  = 1'b0;
        m_tready    = 4'hF;
        m_tready_b  = 3'h7;
        repeat (2) step();

        chk("rst.mux_ready", 64'(mux_ready), 64'd1);
        chk("rst.s_tready", 64'(s_tready), 64'd0);
        chk("rst.tvalid", 64'(m_tvalid), 64'd0);
        chk("rst.seq_err", 64'(seq_err), 64'd0);
        chk("rst.active_dest", 64'(active_dest), 64'd0);
        aresetn = 1'b1;

        // dest=2, len=3: four beats on port 2 only
        cyc("t1.pop", 1, 2'd2, 8'd3, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        chk("t1.active_dest", 64'(active_dest), 64'd2);
        chk("t1.active_pid", 64'(active_pid), 64'h15);
        chk("t1.tkeep", 64'(m_tkeep[2]), 64'hA);
        cyc("t1.b1", 0, 2'd0, 8'd0, 1, 0, 32'h11, 4'b0100, 4'b0000, 1, 0);
        cyc("t1.b2", 0, 2'd0, 8'd0, 1, 0, 32'h12, 4'b0100, 4'b0000, 1, 0);
        cyc("t1.b3", 0, 2'd0, 8'd0, 1, 0, 32'h13, 4'b0100, 4'b0000, 1, 0);
        cyc("t1.b4", 0, 2'd0, 8'd0, 1, 1, 32'h14, 4'b0100, 4'b0100, 1, 1);
        cyc("t1.idle", 0, 2'd0, 8'd0, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        chk("t1.seq_err", 64'(seq_err), 64'd0);

        // back-to-back {0,0},{3,1}; input valid held in IDLE is not accepted
        cyc("t2.pop", 1, 2'd0, 8'd0, 1, 1, 32'h21, 4'b0000, 4'b0000, 0, 1);
        cyc("t2.b1", 1, 2'd3, 8'd1, 1, 1, 32'h21, 4'b0001, 4'b0001, 1, 1);
        cyc("t2.b2", 0, 2'd0, 8'd0, 1, 0, 32'h22, 4'b1000, 4'b0000, 1, 0);
        cyc("t2.b3", 0, 2'd0, 8'd0, 1, 1, 32'h23, 4'b1000, 4'b1000, 1, 1);
        cyc("t2.idle", 0, 2'd0, 8'd0, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        chk("t2.seq_err", 64'(seq_err), 64'd0);

        // dest=1, len=7 with port-1 tready cycling 1,0,0
        cyc("t3.pop", 1, 2'd1, 8'd7, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        beats = 0;
        for (int i = 0; i < 40 && beats < 8; i++) begin
            tr = (i % 3 == 0);
            m_tready = {2'b00, tr, 1'b0};
            cyc("t3.beat", 0, 2'd0, 8'd0, 1, (beats == 7), 32'h300 + 32'(beats),
                4'b0010, (beats == 7) ? 4'b0010 : 4'b0000, tr, tr && (beats == 7));
            if (tr) beats++;
        end
        chk("t3.beats", 64'(beats), 64'd8);
        m_tready = 4'hF;
        cyc("t3.idle", 0, 2'd0, 8'd0, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        chk("t3.seq_err", 64'(seq_err), 64'd0);

        // dest=0, len=2 with early input tlast on beat 2
        cyc("t4.pop", 1, 2'd0, 8'd2, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        cyc("t4.b1", 0, 2'd0, 8'd0, 1, 0, 32'h41, 4'b0001, 4'b0000, 1, 0);
        chk("t4.err_b1", 64'(seq_err), 64'd0);
        cyc("t4.b2", 0, 2'd0, 8'd0, 1, 1, 32'h42, 4'b0001, 4'b0000, 1, 0);
        chk("t4.err_b2", 64'(seq_err), 64'd1);
        cyc("t4.b3", 0, 2'd0, 8'd0, 1, 0, 32'h43, 4'b0001, 4'b0001, 1, 1);
        cyc("t4.idle", 0, 2'd0, 8'd0, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        chk("t4.sticky", 64'(seq_err), 64'd1);

        // reset at beat 2 of 5 abandons the transfer and clears seq_err
        cyc("t6.pop", 1, 2'd1, 8'd4, 0, 0, 32'h0, 4'b0000, 4'b0000, 0, 1);
        cyc("t6.b1", 0, 2'd0, 8'd0, 1, 0, 32'h61, 4'b0010, 4'b0000, 1, 0);
        s_tdata = 32'h62;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        chk("t6.tvalid", 64'(m_tvalid), 64'd0);
        chk("t6.s_tready", 64'(s_tready), 64'd0);
        chk("t6.seq_err", 64'(seq_err), 64'd0);
        chk("t6.mux_ready", 64'(mux_ready), 64'd1);
        s_tvalid = 1'b0;
        step();

        // N_DESTS=3 instance: dest=3 is out of range and is drained
        mux_valid_b = 1'b1;
        mux_dest    = 2'd3;
        mux_len     = 8'd1;
        #1;
        chk("t5.pop_ready", 64'(mux_ready_b), 64'd1);
        step();
        mux_valid_b = 1'b0;
        s_tvalid_b  = 1'b1;
        s_tlast     = 1'b0;
        #1;
        chk("t5.b1_tready", 64'(s_tready_b), 64'd1);
        chk("t5.b1_tvalid", 64'(m_tvalid_b), 64'd0);
        chk("t5.b1_mux_ready", 64'(mux_ready_b), 64'd0);
        step();
        s_tlast = 1'b1;
        #1;
        chk("t5.b2_err", 64'(seq_err_b), 64'd1);
        chk("t5.b2_tready", 64'(s_tready_b), 64'd1);
        chk("t5.b2_tvalid", 64'(m_tvalid_b), 64'd0);
        chk("t5.b2_mux_ready", 64'(mux_ready_b), 64'd1);
        step();
        s_tvalid_b = 1'b0;
        s_tlast    = 1'b0;
        #1;
        chk("t5.idle_tready", 64'(s_tready_b), 64'd0);
        chk("t5.idle_mux_ready", 64'(mux_ready_b), 64'd1);
        chk("t5.seq_err", 64'(seq_err_b), 64'd1);
        chk("t5.a_err", 64'(seq_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
